// File: rtl/screen_draw_scheduler_pkg.sv
// Shared types for the screen redraw scheduler.
// Cell codes, FSM state encoding and a log2 helper.
package screen_draw_scheduler_pkg;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_BG    = 2'd0;
  localparam cell_t CELL_SNAKE = 2'd1;
  localparam cell_t CELL_COIN  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SNAKE,
    ST_COIN,
    ST_DONE
  } state_e;

  function automatic int logb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/screen_draw_scheduler_if.sv
// Screen RAM write port shared by clear, snake and coin sources.
// The scheduler is the master, the RAM the slave.
interface screen_draw_scheduler_if #(
  parameter int ADDR_BITS = 10
);
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [1:0]           mem_data;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_data
  );

  modport slave (
    input mem_we,
    input mem_addr,
    input mem_data
  );
endinterface

// File: rtl/screen_draw_scheduler_counter.sv
// Wrapping counter 0..LIMIT; ovf flags the enabled cycle at LIMIT.
// Drives the clear-sweep address of the scheduler.
module screen_draw_scheduler_counter #(
  parameter int W     = 10,
  parameter int LIMIT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         ovf
);

  assign ovf = en && (count == W'(LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= ovf ? '0 : count + W'(1);
  end

endmodule

// File: rtl/screen_draw_scheduler.sv
// Frame redraw sequencer: clear sweep, snake body, coin.
// Owns the single screen RAM write port; outputs are registered.
module screen_draw_scheduler
  import screen_draw_scheduler_pkg::*;
#(
  parameter int H         = 32,
  parameter int V         = 32,
  parameter int ADDR_BITS = 10,
  parameter int X_BITS    = 5,
  parameter int Y_BITS    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              game_tick,
  input  logic              snake_valid,
  input  logic [X_BITS-1:0] snake_x,
  input  logic [Y_BITS-1:0] snake_y,
  input  logic              snake_done,
  input  logic              coin_valid,
  input  logic [X_BITS-1:0] coin_x,
  input  logic [Y_BITS-1:0] coin_y,
  output logic              snake_start,
  screen_draw_scheduler_if.master mem,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int CELLS    = H * V;
  localparam int CNT_BITS = (logb2(CELLS) < 1) ? 1 : logb2(CELLS);

  state_e state_q, state_d;

  logic [CNT_BITS-1:0]  count;
  logic                 cnt_en, cnt_clr, cnt_ovf;
  logic                 clr_last;

  logic                 we_d;
  logic [ADDR_BITS-1:0] addr_d;
  cell_t                data_d;
  logic                 start_d;
  logic                 done_d;

  function automatic logic in_range(
    input logic [X_BITS-1:0] x,
    input logic [Y_BITS-1:0] y
  );
    return (int'(x) < H) && (int'(y) < V);
  endfunction

  function automatic logic [ADDR_BITS-1:0] cell_addr(
    input logic [X_BITS-1:0] x,
    input logic [Y_BITS-1:0] y
  );
    return ADDR_BITS'(y) * ADDR_BITS'(H) + ADDR_BITS'(x);
  endfunction

  // Counter leads the displayed address by one write.
  assign cnt_en  = (state_q == ST_IDLE && game_tick)
                || (state_q == ST_CLEAR && !clr_last);
  assign cnt_clr = (state_q != ST_CLEAR) && !cnt_en;

  screen_draw_scheduler_counter #(
    .W     (CNT_BITS),
    .LIMIT (CELLS - 1)
  ) u_clr_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (count),
    .ovf   (cnt_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (game_tick)  state_d = ST_CLEAR;
      ST_CLEAR: if (clr_last)   state_d = ST_SNAKE;
      ST_SNAKE: if (snake_done) state_d = ST_COIN;
      ST_COIN:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    addr_d  = '0;
    data_d  = CELL_BG;
    start_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        we_d   = game_tick;
        addr_d = ADDR_BITS'(count);
      end
      ST_CLEAR: begin
        we_d    = !clr_last;
        addr_d  = ADDR_BITS'(count);
        start_d = clr_last;
      end
      ST_SNAKE: begin
        we_d   = snake_valid && in_range(snake_x, snake_y);
        addr_d = cell_addr(snake_x, snake_y);
        data_d = CELL_SNAKE;
      end
      ST_COIN: begin
        we_d   = coin_valid && in_range(coin_x, coin_y);
        addr_d = cell_addr(coin_x, coin_y);
        data_d = CELL_COIN;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_data <= CELL_BG;
      snake_start  <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      clr_last     <= 1'b0;
    end else begin
      mem.mem_we   <= we_d;
      mem.mem_addr <= addr_d;
      mem.mem_data <= data_d;
      snake_start  <= start_d;
      frame_done   <= done_d;
      busy         <= (state_d != ST_IDLE);
      overrun      <= overrun | (game_tick && state_q != ST_IDLE);
      clr_last     <= cnt_ovf;
    end
  end

endmodule
